// File: rtl/fp_accumulator.sv
// fp_accumulator: streaming IEEE-754 single-precision accumulator.
// Terms arrive over a valid/ready handshake and are folded into a running
// sum by one combinational Addition_Subtraction unit. The beat flagged last
// publishes the sum, a sticky exception flag and a saturating term count on
// a registered valid/ready output port.
module fp_accumulator #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    input  logic               in_sub,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic               out_exception,
    output logic [COUNT_W-1:0] out_count
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state;
    logic [31:0]        acc;
    logic               exc;
    logic [COUNT_W-1:0] cnt;

    logic [31:0]        sum;
    logic               sum_exc;
    logic               exc_next;
    logic [COUNT_W-1:0] cnt_next;

    Addition_Subtraction u_adder (
        .a_operand  (acc),
        .b_operand  (in_data),
        .AddBar_Sub (in_sub),
        .Exception  (sum_exc),
        .result     (sum)
    );

    assign exc_next = exc | sum_exc;
    assign cnt_next = (&cnt) ? cnt : cnt + COUNT_W'(1);

    // Only the state register drives in_ready, so out_ready never reaches it.
    assign in_ready = (state == ACCUM);

    // Accumulate accepted terms, publish on last, and release on out_ready.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ACCUM;
            acc           <= 32'd0;
            exc           <= 1'b0;
            cnt           <= '0;
            out_valid     <= 1'b0;
            out_data      <= 32'd0;
            out_exception <= 1'b0;
            out_count     <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        acc <= sum;
                        exc <= exc_next;
                        cnt <= cnt_next;
                        if (in_last) begin
                            out_data      <= sum;
                            out_exception <= exc_next;
                            out_count     <= cnt_next;
                            out_valid     <= 1'b1;
                            state         <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        acc       <= 32'd0;
                        exc       <= 1'b0;
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// Addition_Subtraction: combinational single-precision add/subtract.
// Inf/NaN on either input raises Exception and forces a zero result. A
// zero-magnitude operand returns the other operand bit-exact (no sign flip,
// even for subtraction). Otherwise magnitudes are aligned, added or
// subtracted, normalised and truncated; overflow saturates to infinity.
module Addition_Subtraction (
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    input  logic        AddBar_Sub,
    output logic        Exception,
    output logic [31:0] result
);

    logic        zero_a;
    logic        zero_b;
    logic        b_sign;
    logic        swap;
    logic        big_sign;
    logic        small_sign;
    logic [30:0] big_mag;
    logic [30:0] small_mag;
    logic [7:0]  big_exp;
    logic [7:0]  small_exp;
    logic [7:0]  shift;
    logic [23:0] big_man;
    logic [23:0] small_man;
    logic [23:0] small_al;
    logic [24:0] mag;
    logic [23:0] norm;
    logic [9:0]  exp_w;
    logic [9:0]  lz;

    // Order operands by magnitude, align, combine, normalise and pack.
    // NOTE: every combinational output is assigned on every path through the
    // block, so no latch can be inferred.
    always_comb begin
        Exception  = (&a_operand[30:23]) | (&b_operand[30:23]);
        zero_a     = (a_operand[30:0] == 31'd0);
        zero_b     = (b_operand[30:0] == 31'd0);
        b_sign     = b_operand[31] ^ AddBar_Sub;

        swap       = (b_operand[30:0] > a_operand[30:0]);
        big_mag    = swap ? b_operand[30:0] : a_operand[30:0];
        small_mag  = swap ? a_operand[30:0] : b_operand[30:0];
        big_sign   = swap ? b_sign : a_operand[31];
        small_sign = swap ? a_operand[31] : b_sign;

        // Subnormals share the minimum exponent and have no hidden one.
        big_exp    = (big_mag[30:23] == 8'd0) ? 8'd1 : big_mag[30:23];
        small_exp  = (small_mag[30:23] == 8'd0) ? 8'd1 : small_mag[30:23];
        big_man    = {|big_mag[30:23], big_mag[22:0]};
        small_man  = {|small_mag[30:23], small_mag[22:0]};
        shift      = big_exp - small_exp;
        small_al   = (shift > 8'd23) ? 24'd0 : (small_man >> shift);

        if (big_sign == small_sign) begin
            mag = {1'b0, big_man} + {1'b0, small_al};
        end else begin
            mag = {1'b0, big_man} - {1'b0, small_al};
        end

        // Leading-zero count of the 24-bit field; the highest set bit wins.
        lz = 10'd24;
        for (int i = 0; i < 24; i++) begin
            if (mag[i]) begin
                lz = 10'(23 - i);
            end
        end

        exp_w = {2'b00, big_exp};
        if (mag[24]) begin
            norm  = mag[24:1];
            exp_w = exp_w + 10'd1;
        end else begin
            // Never shift below the minimum exponent: the result goes subnormal.
            if (lz > exp_w - 10'd1) begin
                lz = exp_w - 10'd1;
            end
            norm  = mag[23:0] << lz;
            exp_w = exp_w - lz;
        end

        if (Exception) begin
            result = 32'd0;
        end else if (zero_a) begin
            result = b_operand;
        end else if (zero_b) begin
            result = a_operand;
        end else if (mag == 25'd0) begin
            result = 32'd0;
        end else if (exp_w >= 10'd255) begin
            result = {big_sign, 8'hFF, 23'd0};
        end else begin
            result = {big_sign, (norm[23] ? exp_w[7:0] : 8'd0), norm[22:0]};
        end
    end

endmodule

// File: doc/fp_accumulator.md
# fp_accumulator

Streaming IEEE-754 single-precision accumulator that sits directly upstream of the output register stage of the filter datapath. It consumes a stream of 32-bit float terms, such as tap products, over a valid/ready handshake. Each term is folded into a running sum by one instance of the team's combinational `Addition_Subtraction` unit. On the beat flagged last, it presents the registered sum, a sticky exception flag and a term count on a valid/ready output port.

## Interface
- `COUNT_W`, default 8: width of the term counter. The counter saturates at 2^COUNT_W−1.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- `in_valid`  input  1  term present on `in_data`.
- `in_ready`  output  1  block can accept a term this cycle.
- `in_data`  input  32  IEEE-754 term.
- `in_sub`  input  1  0: acc + term; 1: acc − term. Driven straight to `AddBar_Sub`.
- `in_last`  input  1  term closes the current sum.
- `out_valid`  output  1  sum available.
- `out_ready`  input  1  downstream accepts sum.
- `out_data`  output  32  accumulated IEEE-754 sum.
- `out_exception`  output  1  OR of the adder `Exception` over every term of this sum.
- `out_count`  output  COUNT_W  number of terms accepted for this sum, saturating.

## Operation
- The block has two states: ACCUM and HOLD. Reset enters ACCUM.
- The adder instance is wired as follows:
  - `a_operand` = `acc`.
  - `b_operand` = `in_data`.
  - `AddBar_Sub` = `in_sub`.
  - The adder's result and `Exception` are used only on an accepted beat.
- **ACCUM state**
  - `in_ready`=1 and `out_valid`=0.
  - On accept (`in_valid & in_ready`):
    - `acc` ← adder result.
    - `exc` ← `exc | Exception`.
    - `cnt` ← `cnt+1`, saturating at all-ones.
  - If `in_last` is set on the accepted beat:
    - The same new values are loaded into `out_data`, `out_exception` and `out_count`.
    - The state moves to HOLD.
- **HOLD state**
  - `in_ready`=0 and `out_valid`=1.
  - Output registers are held stable until `out_ready`=1.
  - On `out_ready`=1: `acc`, `exc` and `cnt` clear to 0, and the state returns to ACCUM.
- A first term added to `acc`=0 passes through bit-exact, because the adder returns the other operand when one operand's magnitude is zero.
- If the adder flags `Exception`, its result is 0. That 0 is loaded into `acc`, and later terms continue to accumulate from it. The sticky `exc` bit remains set until the sum is delivered.
- Subtraction of the first term yields the term unchanged. This is the adder's zero-operand rule, and it is required behaviour, not a bug.
- Beats with `in_valid`=0 change no state.
- In HOLD, `in_data`, `in_sub` and `in_last` are ignored.

## Timing
- **Reset values:**
  - `in_ready`=1.
  - `out_valid`=0.
  - `out_data`=0x00000000.
  - `out_exception`=0.
  - `out_count`=0.
  - `acc`=0, `exc`=0, `cnt`=0.
  - State = ACCUM.
- **Throughput:** one term per cycle in ACCUM.
- **Latency:** if the last term is accepted at edge N, `out_valid` is high from edge N until the edge where `out_ready` is sampled high. At that edge, `out_valid` falls and `in_ready` rises after the edge.
- **Minimum gap between sums:** one cycle with `in_ready`=0, even when `out_ready` is held high.
- **No combinational paths:**
  - None from `out_ready` to `in_ready`.
  - None from `in_valid` to `out_valid`.
  - All outputs are registered, except that `in_ready` may be decoded from the state register.
- **Reset priority:** `reset` overrides every other input in the same cycle, mid-sum or in HOLD. A pending sum is discarded and all outputs return to their reset values on the next edge.
- **Counter saturation:** `out_count` stays at 2^COUNT_W−1 for longer sums. The sum itself is unaffected.

## Test plan
- **Add two terms:** 0x3F800000 (1.0), then 0x40000000 (2.0) with `in_last`, `out_ready`=1. Required: `out_data`=0x40400000, `out_count`=2, `out_exception`=0. `out_valid` is high for one cycle, then `in_ready` returns.
- **Subtract:** 0x40400000 (3.0), then 0x3F800000 with `in_sub`=1 and `in_last`. Required: `out_data`=0x40000000. Single-beat case: 0x3FC00000 with `in_last`. Required: `out_data`=0x3FC00000, `out_count`=1.
- **Exception:** 0x3F800000, then 0x7F800000 (inf), then 0x3F000000 (0.5) with `in_last`. Required: `out_exception`=1, `out_data`=0x3F000000, `out_count`=3.
- **Backpressure:** complete a sum with `out_ready`=0 for 3 cycles while `in_valid` stays high. Required: `out_valid`=1, `out_data` stable, `in_ready`=0 throughout, no term consumed. After `out_ready` rises, the next sum starts from 0.
- **Reset mid-sum:** feed 1.0 and 2.0 (not last), then pulse `reset`, then send 0x40000000 with `in_last`. Required: `out_data`=0x40000000, `out_count`=1.
- **Counter saturation:** with `COUNT_W`=2, send five 0x3F800000 terms, the last with `in_last`. Required: `out_data`=0x40A00000, `out_count`=3.
